// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared MemSize encodings and data-memory FSM states
package mips_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects byte/half/word from a memory word by lane and extends it
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    rd_o     = 32'h0;
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_B:  rd_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_H:  rd_o = {{16{sign_i & half_sel[15]}}, half_sel};
      SIZE_W:  rd_o = word_i;
      default: rd_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// rtl/dmem_byte_ctrl.sv - byte-addressed data memory with sized loads/stores and clear sweep
// Optional test_value port (RAM[0][15:0]) enabled by DMEM_TEST_PORT_EN.
module dmem_byte_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WD,
  input  logic              WE,
  input  logic [1:0]        MemSize,
  input  logic              MemSign,
  input  logic              CLR,
  output logic [31:0]       RD,
  output logic              MisAlign,
  output logic              OutOfRange,
  output logic              Busy
`ifdef DMEM_TEST_PORT_EN
  ,
  output logic [15:0]       test_value
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ADDR_W - 2;

  logic [31:0] mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [PTR_W-1:0] ram_idx;
  logic [31:0]      rd_word;
  logic [31:0]      ext_rd;

  logic [3:0]       be;
  logic [31:0]      wrep;
  logic [31:0]      mask;
  logic [31:0]      merged;

  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata;

  assign word_idx = Address[ADDR_W-1:2];
  assign lane     = Address[1:0];
  assign ram_idx  = word_idx[PTR_W-1:0];
  assign rd_word  = mem_q[ram_idx];

  assign Busy       = (state_q == ST_CLEAR);
  assign OutOfRange = (64'(word_idx) >= 64'(DEPTH));

  always_comb begin
    MisAlign = 1'b0;
    case (MemSize)
      SIZE_B:  MisAlign = 1'b0;
      SIZE_H:  MisAlign = lane[0];
      SIZE_W:  MisAlign = (lane != 2'b00);
      default: MisAlign = 1'b1;
    endcase
  end

  load_extend u_load_extend (
    .word_i (rd_word),
    .lane_i (lane),
    .size_i (MemSize),
    .sign_i (MemSign),
    .rd_o   (ext_rd)
  );

  assign RD = (Busy || OutOfRange || MisAlign) ? 32'h0 : ext_rd;

  // Stores are a read-modify-write of the whole word so the array stays a plain RAM.
  always_comb begin
    be   = 4'b0000;
    wrep = WD;
    case (MemSize)
      SIZE_B: begin
        be   = 4'b0001 << lane;
        wrep = {4{WD[7:0]}};
      end
      SIZE_H: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{WD[15:0]}};
      end
      SIZE_W: begin
        be   = 4'b1111;
        wrep = WD;
      end
      default: begin
        be   = 4'b0000;
        wrep = WD;
      end
    endcase
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged = (rd_word & ~mask) | (wrep & mask);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ram_we    = 1'b0;
    ram_waddr = ram_idx;
    ram_wdata = merged;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = 32'h0;
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          ram_we = WE && !MisAlign && !OutOfRange;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

`ifdef DMEM_TEST_PORT_EN
  assign test_value = mem_q[0][15:0];
`endif

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// tb/tb_dmem_byte_ctrl.sv - directed self-checking bench for dmem_byte_ctrl
module tb_dmem_byte_ctrl;

  localparam int DEPTH = 256;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SR = 2'b11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [1:0]  MemSize = SW;
  logic        MemSign = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] RD;
  logic        MisAlign;
  logic        OutOfRange;
  logic        Busy;
`ifdef DMEM_TEST_PORT_EN
  logic [15:0] test_value;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dmem_byte_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Address    (Address),
    .WD         (WD),
    .WE         (WE),
    .MemSize    (MemSize),
    .MemSign    (MemSign),
    .CLR        (CLR),
    .RD         (RD),
    .MisAlign   (MisAlign),
    .OutOfRange (OutOfRange),
    .Busy       (Busy)
`ifdef DMEM_TEST_PORT_EN
    ,
    .test_value (test_value)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(negedge CLK);
    Address = a; WD = d; MemSize = s; WE = 1'b1;
    @(posedge CLK);
    #1;
    WE = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
    @(negedge CLK);
    Address = a; MemSize = s; MemSign = sg;
    #1;
  endtask

  // Counts rising edges until Busy drops; 1000 means the bound expired.
  task automatic count_busy(input int clr_at, output int cnt);
    cnt = 1000;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge CLK);
      #1;
      CLR = (i == clr_at);
      if (!Busy) begin
        cnt = i;
        break;
      end
    end
    CLR = 1'b0;
  endtask

  task automatic count_nonzero(output int errs);
    errs = 0;
    @(negedge CLK);
    MemSize = SW; MemSign = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      Address = 32'(i * 4);
      #0.1;
      if (RD !== 32'h0) errs++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    int errs;
    #12;
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", Busy); end
    set_load(32'h0, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected 00000000", RD); end
    @(negedge CLK);
    RST = 1'b0;
    count_busy(0, cnt);
    n_checks++;
    if (cnt !== 256) begin n_fail++; $display("FAIL reset_sweep_len: got %0d expected 256", cnt); end
    count_nonzero(errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL reset_all_zero: got %0d nonzero words expected 0", errs); end
`ifdef DMEM_TEST_PORT_EN
    n_checks++;
    if (test_value !== 16'h0) begin n_fail++; $display("FAIL reset_test_value: got %h expected 0000", test_value); end
`endif
  endtask

  task automatic test_byte();
    drive_store(32'h10, 32'h11223344, SW);
    set_load(32'h10, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h11223344) begin n_fail++; $display("FAIL sw_readback: got %h expected 11223344", RD); end
    drive_store(32'h13, 32'h000000A5, SB);
    set_load(32'h10, SW, 1'b0);
    n_checks++;
    if (RD !== 32'hA5223344) begin n_fail++; $display("FAIL sb_merge: got %h expected a5223344", RD); end
    set_load(32'h13, SB, 1'b1);
    n_checks++;
    if (RD !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_sign: got %h expected ffffffa5", RD); end
    set_load(32'h13, SB, 1'b0);
    n_checks++;
    if (RD !== 32'h000000A5) begin n_fail++; $display("FAIL lbu: got %h expected 000000a5", RD); end
    set_load(32'h12, SB, 1'b1);
    n_checks++;
    if (RD !== 32'h00000022) begin n_fail++; $display("FAIL lb_lane2: got %h expected 00000022", RD); end
    set_load(32'h11, SB, 1'b0);
    n_checks++;
    if (RD !== 32'h00000033) begin n_fail++; $display("FAIL lbu_lane1: got %h expected 00000033", RD); end
  endtask

  task automatic test_half();
    drive_store(32'h22, 32'h00008001, SH);
    set_load(32'h20, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h80010000) begin n_fail++; $display("FAIL sh_upper: got %h expected 80010000", RD); end
    set_load(32'h22, SH, 1'b1);
    n_checks++;
    if (RD !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sign: got %h expected ffff8001", RD); end
    set_load(32'h22, SH, 1'b0);
    n_checks++;
    if (RD !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h expected 00008001", RD); end
    drive_store(32'h20, 32'hDEAD7FFF, SH);
    set_load(32'h20, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h80017FFF) begin n_fail++; $display("FAIL sh_lower: got %h expected 80017fff", RD); end
    set_load(32'h20, SH, 1'b1);
    n_checks++;
    if (RD !== 32'h00007FFF) begin n_fail++; $display("FAIL lh_positive: got %h expected 00007fff", RD); end
  endtask

  task automatic test_read_during_write();
    @(negedge CLK);
    Address = 32'h10; WD = 32'hCAFEBABE; MemSize = SW; WE = 1'b1;
    #1;
    n_checks++;
    if (RD !== 32'hA5223344) begin n_fail++; $display("FAIL rdw_old: got %h expected a5223344", RD); end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    #1;
    n_checks++;
    if (RD !== 32'hCAFEBABE) begin n_fail++; $display("FAIL rdw_new: got %h expected cafebabe", RD); end
  endtask

  task automatic test_misalign();
    drive_store(32'h04, 32'h55667788, SW);
    drive_store(32'h08, 32'h99AABBCC, SW);
    @(negedge CLK);
    Address = 32'h06; WD = 32'hFFFFFFFF; MemSize = SW; WE = 1'b1;
    #1;
    n_checks++;
    if (MisAlign !== 1'b1 || RD !== 32'h0) begin
      n_fail++; $display("FAIL sw_misalign: got ma=%b rd=%h expected ma=1 rd=00000000", MisAlign, RD);
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    set_load(32'h04, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h55667788 || MisAlign !== 1'b0) begin
      n_fail++; $display("FAIL sw_misalign_nowrite4: got rd=%h ma=%b expected 55667788 0", RD, MisAlign);
    end
    set_load(32'h08, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h99AABBCC) begin n_fail++; $display("FAIL sw_misalign_nowrite8: got %h expected 99aabbcc", RD); end
    set_load(32'h05, SH, 1'b0);
    n_checks++;
    if (MisAlign !== 1'b1 || RD !== 32'h0) begin
      n_fail++; $display("FAIL lh_misalign: got ma=%b rd=%h expected 1 00000000", MisAlign, RD);
    end
    set_load(32'h04, SR, 1'b0);
    n_checks++;
    if (MisAlign !== 1'b1 || RD !== 32'h0) begin
      n_fail++; $display("FAIL size_reserved: got ma=%b rd=%h expected 1 00000000", MisAlign, RD);
    end
    set_load(32'h05, SB, 1'b0);
    n_checks++;
    if (MisAlign !== 1'b0 || RD !== 32'h00000077) begin
      n_fail++; $display("FAIL lb_odd_ok: got ma=%b rd=%h expected 0 00000077", MisAlign, RD);
    end
  endtask

  task automatic test_out_of_range();
    drive_store(32'h00, 32'h01020304, SW);
    @(negedge CLK);
    Address = 32'h400; WD = 32'hDEADBEEF; MemSize = SW; WE = 1'b1;
    #1;
    n_checks++;
    if (OutOfRange !== 1'b1 || RD !== 32'h0) begin
      n_fail++; $display("FAIL sw_oor: got oor=%b rd=%h expected 1 00000000", OutOfRange, RD);
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    set_load(32'h00, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h01020304) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 01020304", RD); end
`ifdef DMEM_TEST_PORT_EN
    n_checks++;
    if (test_value !== 16'h0304) begin n_fail++; $display("FAIL test_value_word0: got %h expected 0304", test_value); end
`endif
    set_load(32'h3FC, SW, 1'b0);
    n_checks++;
    if (OutOfRange !== 1'b0) begin n_fail++; $display("FAIL last_word_in_range: got %b expected 0", OutOfRange); end
  endtask

  task automatic test_clear_vs_store();
    int cnt;
    int errs;
    @(negedge CLK);
    Address = 32'h30; WD = 32'h12345678; MemSize = SW; WE = 1'b1; CLR = 1'b1;
    @(posedge CLK);
    #1;
    WE = 1'b0; CLR = 1'b0;
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b expected 1", Busy); end
    // A store to word 0 after the pointer has passed it, plus a CLR pulse, must not disturb the sweep.
    for (int i = 0; i < 100; i++) @(posedge CLK);
    @(negedge CLK);
    Address = 32'h00; WD = 32'hFFFFFFFF; WE = 1'b1;
    @(posedge CLK);
    #1;
    WE = 1'b0;
    count_busy(20, cnt);
    n_checks++;
    if (cnt !== 256 - 101) begin n_fail++; $display("FAIL clr_sweep_len: got %0d expected %0d", cnt, 256 - 101); end
    count_nonzero(errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL clr_all_zero: got %0d nonzero words expected 0", errs); end
`ifdef DMEM_TEST_PORT_EN
    n_checks++;
    if (test_value !== 16'h0) begin n_fail++; $display("FAIL clr_test_value: got %h expected 0000", test_value); end
`endif
  endtask

  task automatic test_rst_mid_sweep();
    int cnt;
    drive_store(32'h40, 32'h0BADF00D, SW);
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    for (int i = 0; i < 99; i++) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 1", Busy); end
    @(negedge CLK);
    RST = 1'b0;
    count_busy(0, cnt);
    n_checks++;
    if (cnt !== 256) begin n_fail++; $display("FAIL rst_mid_sweep_len: got %0d expected 256", cnt); end
    set_load(32'h40, SW, 1'b0);
    n_checks++;
    if (RD !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cleared: got %h expected 00000000", RD); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_read_during_write();
    test_misalign();
    test_out_of_range();
    test_clear_vs_store();
    test_rst_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
